alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execute-stage ALU that consumes the 4-bit alu_func code produced by alu_control, plus two operands and a branch qualifier.
- Single-cycle ops (add/sub/logic/compare/branch) take 1 cycle. Shifts are iterative, one bit per cycle, to save area.
- Valid/ready handshakes on both sides let the pipeline control stall EX while a shift runs.
- A flush input aborts the in-flight operation.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; shift amount is in_b[SHAMT_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the current op; takes effect at the next edge.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- alu_func  in  4  op code (`OP_* values from the shared defines file).
- is_branch  in  1  interpret alu_func as a branch compare (alu_op==01 upstream).
- in_a  in  XLEN  operand A (rs1).
- in_b  in  XLEN  operand B (rs2/imm).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  ALU result; 0 for branches.
- check  out  1  branch-taken flag; 0 for non-branches.
- err  out  1  alu_func was `OP_EEE or unknown, or is_branch was set with a non-branch code.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset sets state=IDLE and result=0, check=0, err=0, out_valid=0, shift counter=0.
- Reset and flush both dominate every other event in the same cycle.
- Accept: an edge with state==IDLE and in_valid=1. Operands and alu_func are latched; later input changes are ignored.
- Non-shift op, or shift with shamt==0: the result is computed at the accept edge; state->DONE. Latency 1 (out_valid high the cycle after accept).
- Shift (SLL/SRL/SRA) with shamt N>0: state->SHIFT, result reg=in_a, cnt=N.
  - Each edge in SHIFT shifts the result reg by 1 and decrements cnt.
  - The edge where cnt goes 1->0 moves state to DONE.
  - Latency N+1 cycles; maximum 32 when N=31.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SRA fills with the original in_a[XLEN-1].
  - SLL/SRL fill with 0.
  - SLT is signed, SLTU is unsigned; both give result {XLEN-1 zeros, bit}.
- Branch mapping when is_branch=1: check is set as below, result=0.
  - OP_ADD: eq.
  - OP_SUB: ne.
  - OP_OR: signed lt.
  - OP_BGE: signed ge.
  - OP_AND: unsigned lt.
  - OP_BGEU: unsigned ge.
  - Any other code: err=1, check=0.
- Error op (OP_EEE/unknown): latency 1, result=0, check=0, err=1. No exception is raised here; it is reported upstream.
- DONE holds result/check/err stable until out_ready=1. At that edge state->IDLE and out_valid drops.
- in_ready is low in DONE even when out_ready=1, so back-to-back throughput is 1 op per 2 cycles for single-cycle ops.
- flush=1 in any state: next state IDLE, out_valid=0, cnt=0. The result reg may keep stale data. A simultaneous in_valid is not accepted.
- in_valid while busy: ignored; the requester must hold the request until in_ready.
- Outputs are registered; no combinational path from in_* to out_*.

Decomposition:
- Shared defines file (existing): `OP_ADD…`OP_BGEU, `OP_EEE codes. Add XLEN default there if not present. State encodings stay local to the module.
- One sub-module, alu_single_cycle (combinational):
  - inputs: alu_func, is_branch, a, b.
  - outputs: result, check, err for all non-shift ops.
- Iterative shift datapath and FSM live in alu_multicycle.

Test Plan:
- Reset held 2 cycles, then released -> IDLE, in_ready=1, out_valid=0, result=0, check=0, err=0.
- ADD a=0xFFFFFFFF, b=0x00000001, out_ready=1 -> out_valid one cycle after accept, result=0x00000000, check=0, then IDLE next cycle.
- SRA a=0x80000000, b=31 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF. SLL a=0x1, b=0 -> latency 1, result=0x1.
- Branch OP_OR (blt) a=0xFFFFFFFF, b=0x1, is_branch=1 -> check=1, result=0. Same operands with OP_AND (bltu) -> check=0. alu_func=`OP_EEE -> err=1.
- Backpressure: SUB a=5, b=7 with out_ready=0 for 4 cycles -> result=0xFFFFFFFE held stable with out_valid=1 and in_ready=0 throughout; a new in_valid in that window is not accepted.
- SRL a=0xF0000000, b=20, flush pulsed 5 cycles after accept -> IDLE next cycle, out_valid never asserted. A following ADD 2+3 gives result=5 with latency 1.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Shared op codes and widths for the execute-stage ALU.
// Codes not listed here (4'hC..4'hE) are treated as unknown ops.
package alu_multicycle_pkg;
  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLTU = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_BGE  = 4'hA;
  localparam logic [3:0] OP_BGEU = 4'hB;
  localparam logic [3:0] OP_EEE  = 4'hF;

  function automatic logic is_shift(input logic [3:0] f);
    return (f == OP_SLL) || (f == OP_SRL) || (f == OP_SRA);
  endfunction
endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response handshake bundle between pipeline control and the ALU.
interface alu_multicycle_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_func;
  logic            is_branch;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            check;
  logic            err;

  modport master (
    output in_valid, alu_func, is_branch, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, check, err
  );
  modport slave (
    input  in_valid, alu_func, is_branch, in_a, in_b, out_ready,
    output in_ready, out_valid, result, check, err
  );
endinterface

// File: rtl/alu_multicycle_single_cycle.sv
// Combinational datapath for every non-shift op, including branch compares.
// Shift codes produce zeros here; the iterative shifter in the top owns them.
module alu_single_cycle
  import alu_multicycle_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      i_alu_func,
  input  logic            i_is_branch,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_check,
  output logic            o_err
);
  logic w_lt_s, w_lt_u;
  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_result = '0;
    o_check  = 1'b0;
    o_err    = 1'b0;
    if (i_is_branch) begin
      // Upstream reuses the arithmetic codes to select the branch condition.
      case (i_alu_func)
        OP_ADD:  o_check = (i_a == i_b);
        OP_SUB:  o_check = (i_a != i_b);
        OP_OR:   o_check = w_lt_s;
        OP_BGE:  o_check = !w_lt_s;
        OP_AND:  o_check = w_lt_u;
        OP_BGEU: o_check = !w_lt_u;
        default: o_err   = 1'b1;
      endcase
    end else begin
      case (i_alu_func)
        OP_ADD:  o_result = i_a + i_b;
        OP_SUB:  o_result = i_a - i_b;
        OP_AND:  o_result = i_a & i_b;
        OP_OR:   o_result = i_a | i_b;
        OP_XOR:  o_result = i_a ^ i_b;
        OP_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
        OP_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
        OP_SLL, OP_SRL, OP_SRA: o_result = '0;
        default: o_err    = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops finish at the accept edge, shifts
// iterate one bit per cycle; valid/ready on both sides, flush aborts.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  alu_multicycle_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_result;
  logic               r_check;
  logic               r_err;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;

  logic [XLEN-1:0]    w_sc_result;
  logic               w_sc_check;
  logic               w_sc_err;
  logic               w_shift_req;
  logic [SHAMT_W-1:0] w_shamt;

  alu_single_cycle #(.XLEN(XLEN)) u_sc (
    .i_alu_func  (bus.alu_func),
    .i_is_branch (bus.is_branch),
    .i_a         (bus.in_a),
    .i_b         (bus.in_b),
    .o_result    (w_sc_result),
    .o_check     (w_sc_check),
    .o_err       (w_sc_err)
  );

  assign w_shift_req = !bus.is_branch && is_shift(bus.alu_func);
  assign w_shamt     = bus.in_b[SHAMT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_check  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_ADD;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_op    <= bus.alu_func;
          r_check <= w_sc_check;
          r_err   <= w_sc_err;
          if (w_shift_req && (w_shamt != '0)) begin
            r_state  <= S_SHIFT;
            r_result <= bus.in_a;
            r_cnt    <= w_shamt;
          end else begin
            r_state  <= S_DONE;
            r_result <= w_shift_req ? bus.in_a : w_sc_result;
          end
        end
        S_SHIFT: begin
          // MSB is never overwritten during SRA, so it still holds the original sign.
          case (r_op)
            OP_SLL:  r_result <= {r_result[XLEN-2:0], 1'b0};
            OP_SRL:  r_result <= {1'b0, r_result[XLEN-1:1]};
            default: r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
          endcase
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) r_state <= S_DONE;
        end
        S_DONE: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.check     = r_check;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a per-cycle reference model.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_multicycle_if #(.XLEN(XLEN)) bus();
  alu_multicycle #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        e;
  } exp_t;

  function automatic exp_t golden(input logic [3:0] f, input logic br,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int   sh;
    sh = int'(b[4:0]);
    r.res = 32'h0; r.c = 1'b0; r.e = 1'b0;
    if (br) begin
      case (f)
        OP_ADD:  r.c = (a == b);
        OP_SUB:  r.c = (a != b);
        OP_OR:   r.c = ($signed(a) < $signed(b));
        OP_BGE:  r.c = ($signed(a) >= $signed(b));
        OP_AND:  r.c = (a < b);
        OP_BGEU: r.c = (a >= b);
        default: r.e = 1'b1;
      endcase
    end else begin
      case (f)
        OP_ADD:  r.res = a + b;
        OP_SUB:  r.res = a - b;
        OP_AND:  r.res = a & b;
        OP_OR:   r.res = a | b;
        OP_XOR:  r.res = a ^ b;
        OP_SLT:  r.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        OP_SLTU: r.res = (a < b) ? 32'h1 : 32'h0;
        OP_SLL:  r.res = a << sh;
        OP_SRL:  r.res = a >> sh;
        OP_SRA:  r.res = $signed(a) >>> sh;
        default: r.e = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] f, input logic br, input logic [31:0] b);
    if (!br && (f == OP_SLL || f == OP_SRL || f == OP_SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Model: 0 = waiting for request, 1 = busy, 2 = holding a result.
  int   m_phase = 0;
  int   m_wait = 0;
  exp_t m_exp;

  always @(posedge clk) begin
    if (reset || flush) begin
      m_phase <= 0;
      m_wait  <= 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          m_exp <= golden(bus.alu_func, bus.is_branch, bus.in_a, bus.in_b);
          if (lat_of(bus.alu_func, bus.is_branch, bus.in_b) == 1) m_phase <= 2;
          else begin
            m_phase <= 1;
            m_wait  <= lat_of(bus.alu_func, bus.is_branch, bus.in_b) - 1;
          end
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_phase <= 2;
        end
        default: if (bus.out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
      chk("cyc out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("cyc result", bus.result, m_exp.res);
        chk("cyc check", 32'(bus.check), 32'(m_exp.c));
        chk("cyc err", 32'(bus.err), 32'(m_exp.e));
      end
    end
  end

  task automatic run_op(input string nm, input logic [3:0] f, input logic br,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic ec, input logic ee,
                        input int elat);
    int lat;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.alu_func = f; bus.is_branch = br;
    bus.in_a = a; bus.in_b = b; bus.out_ready = 1'b1;
    @(posedge clk); #2;
    // Scramble inputs after accept; the DUT must have latched them.
    bus.in_valid = 1'b0; bus.alu_func = OP_XOR; bus.is_branch = 1'b0;
    bus.in_a = 32'hDEADBEEF; bus.in_b = 32'h3;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " result"}, bus.result, eres);
    chk({nm, " check"}, 32'(bus.check), 32'(ec));
    chk({nm, " err"}, 32'(bus.err), 32'(ee));
    @(posedge clk); #2;
    chk({nm, " idle in_ready"}, 32'(bus.in_ready), 32'h1);
    chk({nm, " idle out_valid"}, 32'(bus.out_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    exp_t g;
    bus.in_valid = 1'b0; bus.alu_func = OP_ADD; bus.is_branch = 1'b0;
    bus.in_a = 32'h0; bus.in_b = 32'h0; bus.out_ready = 1'b1;

    // Pin the reference model with a few hand-computed values.
    g = golden(OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h1);
    chk("model add wrap", g.res, 32'h0);
    g = golden(OP_SRA, 1'b0, 32'h80000000, 32'd31);
    chk("model sra", g.res, 32'hFFFFFFFF);
    g = golden(OP_OR, 1'b1, 32'hFFFFFFFF, 32'h1);
    chk("model blt", 32'(g.c), 32'h1);

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst result", bus.result, 32'h0);
    chk("rst check", 32'(bus.check), 32'h0);
    chk("rst err", 32'(bus.err), 32'h0);

    run_op("add wrap", OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    run_op("sra 31", OP_SRA, 1'b0, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 32);
    run_op("sll 0", OP_SLL, 1'b0, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 1);
    run_op("sll 4", OP_SLL, 1'b0, 32'h3, 32'h4, 32'h30, 1'b0, 1'b0, 5);
    run_op("sll hi bits", OP_SLL, 1'b0, 32'h1, 32'h25, 32'h20, 1'b0, 1'b0, 6);
    run_op("srl 4", OP_SRL, 1'b0, 32'hF0000000, 32'h4, 32'h0F000000, 1'b0, 1'b0, 5);
    run_op("sra 4", OP_SRA, 1'b0, 32'hF0000000, 32'h4, 32'hFF000000, 1'b0, 1'b0, 5);
    run_op("xor", OP_XOR, 1'b0, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F, 1'b0, 1'b0, 1);
    run_op("slt", OP_SLT, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
    run_op("sltu", OP_SLTU, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    run_op("blt", OP_OR, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
    run_op("bltu", OP_AND, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    run_op("beq", OP_ADD, 1'b1, 32'h7, 32'h7, 32'h0, 1'b1, 1'b0, 1);
    run_op("bge", OP_BGE, 1'b1, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1);
    run_op("bgeu", OP_BGEU, 1'b1, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1);
    run_op("eee", OP_EEE, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 1);
    run_op("unknown", 4'hC, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 1);
    run_op("branch sll", OP_SLL, 1'b1, 32'h5, 32'h2, 32'h0, 1'b0, 1'b1, 1);

    // Backpressure: result held while out_ready is low, new request ignored.
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.alu_func = OP_SUB; bus.is_branch = 1'b0;
    bus.in_a = 32'd5; bus.in_b = 32'd7; bus.out_ready = 1'b0;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    chk("bp first valid", 32'(bus.out_valid), 32'h1);
    chk("bp first result", bus.result, 32'hFFFFFFFE);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1; bus.alu_func = OP_ADD; bus.in_a = 32'h1; bus.in_b = 32'h1;
      end
      @(posedge clk); #2;
      chk("bp hold result", bus.result, 32'hFFFFFFFE);
      chk("bp hold valid", 32'(bus.out_valid), 32'h1);
      chk("bp hold in_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp release valid", 32'(bus.out_valid), 32'h0);
    chk("bp release in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #2;
    chk("bp no stray accept", 32'(bus.out_valid), 32'h0);

    // Flush mid-shift.
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.alu_func = OP_SRL; bus.is_branch = 1'b0;
    bus.in_a = 32'hF0000000; bus.in_b = 32'd20; bus.out_ready = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    seen = bus.out_valid;
    repeat (4) begin
      @(posedge clk); #2;
      seen |= bus.out_valid;
    end
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.alu_func = OP_ADD; bus.in_a = 32'h9; bus.in_b = 32'h9;
    @(posedge clk); #2;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush in_ready", 32'(bus.in_ready), 32'h1);
    chk("flush out_valid", 32'(bus.out_valid), 32'h0);
    repeat (25) begin
      @(posedge clk); #2;
      seen |= bus.out_valid;
    end
    chk("flush never valid", 32'(seen), 32'h0);
    run_op("add after flush", OP_ADD, 1'b0, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
